// File: rtl/mod_halfk_pipe_pkg.sv
// Shared defaults and helpers for the multi-lane a * 2^-k mod Q scaling pipeline.
package mod_halfk_pipe_pkg;

  localparam int unsigned PKG_WID   = 12;
  localparam int unsigned PKG_Q     = 3329;
  localparam int unsigned PKG_HALFQ = (PKG_Q + 1) / 2;
  localparam int unsigned PKG_KMAX  = 7;
  localparam int unsigned PKG_LANES = 2;
  localparam int unsigned PKG_KW    = $clog2(PKG_KMAX + 1);

  // LSB position of a lane inside a packed multi-lane vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned wid);
    return lane * wid;
  endfunction

endpackage

// File: rtl/fflopx.sv
// Generic flop cell: asynchronous active-high clear to zero, load when en is high.
module fflopx #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (en) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/mod_half_stage.sv
// One halving stage: every lane becomes x * 2^-1 mod Q when STAGE_IDX <= k, else passes.
module mod_half_stage
  import mod_halfk_pipe_pkg::*;
#(
  parameter int unsigned WID       = PKG_WID,
  parameter int unsigned Q         = PKG_Q,
  parameter int unsigned LANES     = PKG_LANES,
  parameter int unsigned KW        = PKG_KW,
  parameter int unsigned STAGE_IDX = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_vld,
  input  logic [KW-1:0]        in_k,
  input  logic [LANES*WID-1:0] in_x,
  output logic                 out_vld,
  output logic [KW-1:0]        out_k,
  output logic [LANES*WID-1:0] out_x
);

  localparam logic [WID-1:0] HALFQ = WID'((Q + 1) / 2);

  // For x < Q the sum stays below Q, so no wider intermediate is needed.
  function automatic logic [WID-1:0] half_mod(input logic [WID-1:0] x);
    return x[0] ? ((x >> 1) + HALFQ) : (x >> 1);
  endfunction

  logic                 halve;
  logic [LANES*WID-1:0] x_d;

  assign halve = (32'(in_k) >= STAGE_IDX);

  always_comb begin
    x_d = in_x;
    if (halve) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        x_d[lane_lsb(i, WID) +: WID] = half_mod(in_x[lane_lsb(i, WID) +: WID]);
      end
    end
  end

  fflopx #(
    .WIDTH(1)
  ) u_vld (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .din (in_vld),
    .dout(out_vld)
  );

  fflopx #(
    .WIDTH(KW)
  ) u_k (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .din (in_k),
    .dout(out_k)
  );

  fflopx #(
    .WIDTH(LANES * WID)
  ) u_x (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .din (x_d),
    .dout(out_x)
  );

endmodule

// File: rtl/mod_halfk_pipe.sv
// Pipelined multi-lane scaler b = a * 2^-k mod Q with a global-stall valid/ready handshake.
module mod_halfk_pipe
  import mod_halfk_pipe_pkg::*;
#(
  parameter int unsigned WID   = PKG_WID,
  parameter int unsigned Q     = PKG_Q,
  parameter int unsigned KMAX  = PKG_KMAX,
  parameter int unsigned LANES = PKG_LANES,
  parameter int unsigned KW    = $clog2(KMAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [KW-1:0]        in_k,
  input  logic [LANES*WID-1:0] in_a,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [LANES*WID-1:0] out_b
);

  localparam logic [WID-1:0]     QW     = WID'(Q);
  localparam logic [KW-1:0]      KMAX_K = KW'(KMAX);
  localparam longint unsigned    TWO_W  = 64'd1 << WID;

  if ((Q % 2) != 1) begin : gen_chk_q_odd
    $error("mod_halfk_pipe: Q must be odd");
  end
  if (!((64'(Q) < TWO_W) && (TWO_W < 64'(2 * Q)))) begin : gen_chk_q_range
    $error("mod_halfk_pipe: need Q < 2^WID < 2Q");
  end
  if (KMAX < 1) begin : gen_chk_kmax
    $error("mod_halfk_pipe: KMAX must be at least 1");
  end

  logic                 en;
  logic [KW-1:0]        k_sat;
  logic [LANES*WID-1:0] a_red;

  // Index 0 is the input register, index s is the output of halving stage s.
  logic                 vld_pipe [KMAX+1];
  logic [KW-1:0]        k_pipe   [KMAX+1];
  logic [LANES*WID-1:0] x_pipe   [KMAX+1];

  assign en     = ~out_vld | out_rdy;
  assign in_rdy = en;
  assign k_sat  = (in_k > KMAX_K) ? KMAX_K : in_k;

  // Single conditional subtract is enough because 2^WID < 2Q.
  always_comb begin
    a_red = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_a[lane_lsb(i, WID) +: WID] >= QW) begin
        a_red[lane_lsb(i, WID) +: WID] = in_a[lane_lsb(i, WID) +: WID] - QW;
      end else begin
        a_red[lane_lsb(i, WID) +: WID] = in_a[lane_lsb(i, WID) +: WID];
      end
    end
  end

  fflopx #(
    .WIDTH(1)
  ) u_vld0 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .din (in_vld),
    .dout(vld_pipe[0])
  );

  fflopx #(
    .WIDTH(KW)
  ) u_k0 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .din (k_sat),
    .dout(k_pipe[0])
  );

  fflopx #(
    .WIDTH(LANES * WID)
  ) u_x0 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .din (a_red),
    .dout(x_pipe[0])
  );

  for (genvar s = 1; s <= KMAX; s++) begin : gen_stage
    mod_half_stage #(
      .WID      (WID),
      .Q        (Q),
      .LANES    (LANES),
      .KW       (KW),
      .STAGE_IDX(s)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .in_vld (vld_pipe[s-1]),
      .in_k   (k_pipe[s-1]),
      .in_x   (x_pipe[s-1]),
      .out_vld(vld_pipe[s]),
      .out_k  (k_pipe[s]),
      .out_x  (x_pipe[s])
    );
  end

  assign out_vld = vld_pipe[KMAX];
  assign out_b   = x_pipe[KMAX];

endmodule

// File: tb/tb_mod_halfk_pipe.sv
// Scoreboard bench for mod_halfk_pipe: driver pushes expected results, monitor pops on transfer.
module tb_mod_halfk_pipe;

  localparam int unsigned QM  = 3329;
  localparam int unsigned LAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [2:0]  in_k;
  logic [23:0] in_a;
  logic        out_vld;
  logic        out_rdy;
  logic [23:0] out_b;

  typedef struct {
    logic [23:0] b;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   chk_lat;
  bit   rand_rdy;
  bit   hold_pend;
  logic [23:0] hold_b;

  mod_halfk_pipe u_dut (
    .clk    (clk),
    .rst    (rst),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .in_k   (in_k),
    .in_a   (in_a),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_b  (out_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Independent model: (a mod Q) * (2^-1)^k mod Q, with 2^-1 = 1665.
  function automatic logic [11:0] model(input logic [11:0] a, input logic [2:0] k);
    int unsigned r;
    int unsigned p;
    r = (a >= 12'(QM)) ? int'(a) - QM : int'(a);
    p = 1;
    for (int j = 0; j < int'(k); j++) p = (p * 1665) % QM;
    return 12'((r * p) % QM);
  endfunction

  task automatic send(input logic [11:0] a0, input logic [11:0] a1, input logic [2:0] k,
                      input logic [11:0] e0, input logic [11:0] e1);
    int n;
    bit acc;
    exp_t e;
    n   = 0;
    acc = 0;
    in_a   = {a1, a0};
    in_k   = k;
    in_vld = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_rdy) begin
        acc   = 1;
        e.b   = {e1, e0};
        e.cyc = cyc;
        e.lat = chk_lat;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: got no accept want accept within 200 cycles");
    end
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: handshake relation, stall stability, and scoreboard pops on every transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 0;
      end else begin
        chk("in_rdy_rel", 32'(in_rdy), 32'(!out_vld || out_rdy));
        if (hold_pend) begin
          chk("stall_vld", 32'(out_vld), 1);
          chk("stall_b", 32'(out_b), 32'(hold_b));
        end
        hold_pend = out_vld && !out_rdy;
        hold_b    = out_b;
        if (out_vld && out_rdy) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got b=%0d,%0d want no output",
                     out_b[23:12], out_b[11:0]);
          end else begin
            e = sb.pop_front();
            if (out_b !== e.b) begin
              errors++;
              $display("FAIL out_b: got %0d,%0d want %0d,%0d (lane1,lane0)",
                       out_b[23:12], out_b[11:0], e.b[23:12], e.b[11:0]);
            end
            if (e.lat) chk("latency", 32'(cyc - e.cyc), LAT);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [11:0] ta0 [11];
  logic [11:0] ta1 [11];
  logic [2:0]  tk  [11];
  logic [11:0] te0 [11];
  logic [11:0] te1 [11];

  initial begin
    logic [11:0] a0, a1;
    logic [2:0]  k;

    ta0 = '{12'd1,    12'd2, 12'd1,    12'd3329, 12'd4095, 12'd3328, 12'd4095,
            12'd3328, 12'd3, 12'd4094, 12'd3330};
    ta1 = '{12'd1,    12'd2, 12'd5,    12'd4095, 12'd3328, 12'd4095, 12'd4095,
            12'd3,    12'd0, 12'd3330, 12'd3329};
    tk  = '{3'd1, 3'd1, 3'd7, 3'd0, 3'd1, 3'd0, 3'd7, 3'd3, 3'd2, 3'd0, 3'd1};
    te0 = '{12'd1665, 12'd1,   12'd3303, 12'd0,   12'd383, 12'd3328, 12'd58,
            12'd416,  12'd833, 12'd765,  12'd1665};
    te1 = '{12'd1665, 12'd1,   12'd3199, 12'd766, 12'd1664, 12'd766, 12'd58,
            12'd2081, 12'd0,   12'd1,    12'd0};

    rst      = 1'b1;
    in_vld   = 1'b0;
    in_k     = '0;
    in_a     = '0;
    out_rdy  = 1'b1;
    rand_rdy = 0;
    chk_lat  = 1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_out_b", 32'(out_b), 0);
    chk("rst_in_rdy", 32'(in_rdy), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) send(ta0[i], ta1[i], tk[i], te0[i], te1[i]);
    drain();

    for (int i = 0; i < 20; i++) begin
      a0 = 12'($urandom_range(0, 4095));
      a1 = 12'($urandom_range(0, 4095));
      k  = 3'($urandom_range(0, 7));
      send(a0, a1, k, model(a0, k), model(a1, k));
    end
    drain();

    chk_lat  = 0;
    rand_rdy = 1;
    for (int i = 0; i < 30; i++) begin
      a0 = 12'($urandom_range(0, 4095));
      a1 = 12'($urandom_range(0, 4095));
      k  = 3'($urandom_range(0, 7));
      send(a0, a1, k, model(a0, k), model(a1, k));
    end
    drain();
    rand_rdy = 0;
    @(posedge clk);
    #2;
    out_rdy = 1'b1;
    chk_lat = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      a0 = 12'(100 + i);
      a1 = 12'(4000 - i);
      k  = 3'(i % 8);
      send(a0, a1, k, model(a0, k), model(a1, k));
    end
    chk("pre_rst_vld", 32'(out_vld), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_vld", 32'(out_vld), 0);
    chk("async_rst_b", 32'(out_b), 0);
    chk("async_rst_rdy", 32'(in_rdy), 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(12'd1, 12'd5, 3'd7, 12'd3303, 12'd3199);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
